sd_spi_card_responder: RTL and testbench

//  SPI-mode SD card responder: the card end of the link driven by the SD SPI master.

---
 rtl/sd_spi_card_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_sd_spi_card_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card model: decodes CMD0/8/17/55/58 and ACMD41, answers with R1/R3/R7
// and serves 512-byte read blocks whose bytes follow a block-number-seeded ramp.
module sd_spi_card_responder #(
   parameter int INIT_POLLS = 4,
   parameter int NCR_BYTES  = 1,
   parameter int TOKEN_GAP  = 2,
   parameter bit CCS_BIT    = 1'b1
) (
   input  logic       clk210_p,
   input  logic       reset_n_p,
   input  logic       sd_spi_sck_p,
   input  logic       sd_spi_ss_p,
   input  logic       sd_spi_mosi_p,
   output logic       sd_spi_miso_p,
   output logic       card_ready_p,
   output logic       cmd_strobe_p,
   output logic [5:0] last_cmd_p
);
   typedef enum logic [2:0] {CMD_HUNT, RX_CMD, NCR, RESP, GAP, DATA} state_t;

   state_t      r_state;
   logic [1:0]  r_sck_sync, r_ss_sync, r_mosi_sync;
   logic        r_sck_d;
   logic [2:0]  r_bit_cnt, r_byte_cnt, r_resp_left;
   logic [6:0]  r_rx_shift;
   logic [7:0]  r_tx_shift, r_fill_cnt, r_blk, r_init_cnt;
   logic [5:0]  r_cmd_idx, r_last_cmd;
   logic [16:0] r_arg;            // only arg[16:0] is ever consumed
   logic [39:0] r_resp_buf;
   logic [9:0]  r_data_cnt;
   logic        r_data_pend, r_idle, r_app_cmd;
   logic        r_miso, r_card_ready, r_cmd_strobe;

   logic        w_sck_rise, w_sck_fall, w_ss_high;
   logic [7:0]  w_rx_byte, w_r1, w_flags, w_init_next, w_blk;
   logic [31:0] w_tail;
   logic [2:0]  w_len;
   logic        w_data_go, w_idle_next, w_ready_next;

   assign w_sck_rise = r_sck_sync[1] & ~r_sck_d;
   assign w_sck_fall = ~r_sck_sync[1] & r_sck_d;
   assign w_ss_high  = r_ss_sync[1];
   assign w_rx_byte  = {r_rx_shift, r_mosi_sync[1]};
   assign w_blk      = CCS_BIT ? r_arg[7:0] : r_arg[16:9];

   // Command execution, evaluated while the CRC byte is the byte just received
   always_comb begin
      w_idle_next  = r_idle;
      w_ready_next = r_card_ready;
      w_init_next  = r_init_cnt;
      w_flags      = 8'h00;
      w_tail       = 32'h0000_0000;
      w_len        = 3'd1;
      w_data_go    = 1'b0;
      case (r_cmd_idx)
         6'd0: begin
            if (w_rx_byte == 8'h95) begin
               w_idle_next  = 1'b1;
               w_ready_next = 1'b0;
               w_init_next  = 8'(INIT_POLLS);
            end else begin
               w_flags = 8'h08;
            end
         end
         6'd8: begin
            if (w_rx_byte == 8'h87) begin
               w_len  = 3'd5;
               w_tail = {16'h0000, 4'h0, r_arg[11:8], r_arg[7:0]};
            end else begin
               w_flags = 8'h08;
            end
         end
         6'd17: begin
            if (r_idle) w_flags = 8'h04;
            else        w_data_go = 1'b1;
         end
         6'd41: begin
            if (!r_app_cmd) begin
               w_flags = 8'h04;
            end else if (r_init_cnt != 8'd0) begin
               w_init_next = r_init_cnt - 8'd1;
            end else begin
               w_idle_next  = 1'b0;
               w_ready_next = 1'b1;
            end
         end
         6'd55: begin
            w_flags = 8'h00;
         end
         6'd58: begin
            w_len  = 3'd5;
            w_tail = {~r_idle, CCS_BIT & ~r_idle, 6'h3F, 8'h80, 16'h0000};
         end
         default: w_flags = 8'h04;
      endcase
      w_r1 = w_flags | {7'b0, w_idle_next};
   end

   always_ff @(posedge clk210_p or negedge reset_n_p) begin
      if (!reset_n_p) begin
         r_state      <= CMD_HUNT;
         r_sck_sync   <= 2'b00;
         r_ss_sync    <= 2'b11;
         r_mosi_sync  <= 2'b11;
         r_sck_d      <= 1'b0;
         r_bit_cnt    <= 3'd0;
         r_byte_cnt   <= 3'd0;
         r_resp_left  <= 3'd0;
         r_rx_shift   <= 7'd0;
         r_tx_shift   <= 8'hFF;
         r_fill_cnt   <= 8'd0;
         r_blk        <= 8'd0;
         r_init_cnt   <= 8'(INIT_POLLS);
         r_cmd_idx    <= 6'd0;
         r_last_cmd   <= 6'd0;
         r_arg        <= 17'd0;
         r_resp_buf   <= 40'd0;
         r_data_cnt   <= 10'd0;
         r_data_pend  <= 1'b0;
         r_idle       <= 1'b1;
         r_app_cmd    <= 1'b0;
         r_miso       <= 1'b1;
         r_card_ready <= 1'b0;
         r_cmd_strobe <= 1'b0;
      end else begin
         r_sck_sync   <= {r_sck_sync[0], sd_spi_sck_p};
         r_ss_sync    <= {r_ss_sync[0], sd_spi_ss_p};
         r_mosi_sync  <= {r_mosi_sync[0], sd_spi_mosi_p};
         r_sck_d      <= r_sck_sync[1];
         r_cmd_strobe <= 1'b0;
         if (w_ss_high) begin
            r_miso     <= 1'b1;
            r_bit_cnt  <= 3'd0;
            r_state    <= CMD_HUNT;
            r_tx_shift <= 8'hFF;
         end else if (w_sck_fall) begin
            r_miso     <= r_tx_shift[7];
            r_tx_shift <= {r_tx_shift[6:0], 1'b1};
         end else if (w_sck_rise) begin
            r_rx_shift <= w_rx_byte[6:0];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            // Byte boundary: the byte loaded here goes out during the next byte slot
            if (r_bit_cnt == 3'd7) begin
               r_tx_shift <= 8'hFF;
               case (r_state)
                  CMD_HUNT: begin
                     if (w_rx_byte[7:6] == 2'b01) begin
                        r_cmd_idx  <= w_rx_byte[5:0];
                        r_byte_cnt <= 3'd0;
                        r_state    <= RX_CMD;
                     end
                  end
                  RX_CMD: begin
                     if (r_byte_cnt == 3'd4) begin
                        r_cmd_strobe <= 1'b1;
                        r_last_cmd   <= r_cmd_idx;
                        r_app_cmd    <= (r_cmd_idx == 6'd55);
                        r_idle       <= w_idle_next;
                        r_card_ready <= w_ready_next;
                        r_init_cnt   <= w_init_next;
                        r_data_pend  <= w_data_go;
                        r_blk        <= w_blk;
                        r_resp_buf   <= {w_r1, w_tail};
                        r_resp_left  <= w_len;
                        if (NCR_BYTES == 0) begin
                           r_tx_shift  <= w_r1;
                           r_resp_buf  <= {w_tail, 8'h00};
                           r_resp_left <= w_len - 3'd1;
                           r_state     <= RESP;
                        end else begin
                           r_fill_cnt <= 8'(NCR_BYTES - 1);
                           r_state    <= NCR;
                        end
                     end else begin
                        r_arg      <= {r_arg[8:0], w_rx_byte};
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                     end
                  end
                  NCR: begin
                     if (r_fill_cnt == 8'd0) begin
                        r_tx_shift  <= r_resp_buf[39:32];
                        r_resp_buf  <= {r_resp_buf[31:0], 8'h00};
                        r_resp_left <= r_resp_left - 3'd1;
                        r_state     <= RESP;
                     end else begin
                        r_fill_cnt <= r_fill_cnt - 8'd1;
                     end
                  end
                  RESP: begin
                     if (r_resp_left != 3'd0) begin
                        r_tx_shift  <= r_resp_buf[39:32];
                        r_resp_buf  <= {r_resp_buf[31:0], 8'h00};
                        r_resp_left <= r_resp_left - 3'd1;
                     end else if (r_data_pend) begin
                        r_data_cnt <= 10'd0;
                        if (TOKEN_GAP == 0) begin
                           r_tx_shift <= 8'hFE;
                           r_state    <= DATA;
                        end else begin
                           r_fill_cnt <= 8'(TOKEN_GAP - 1);
                           r_state    <= GAP;
                        end
                     end else begin
                        r_state <= CMD_HUNT;
                     end
                  end
                  GAP: begin
                     if (r_fill_cnt == 8'd0) begin
                        r_tx_shift <= 8'hFE;
                        r_state    <= DATA;
                     end else begin
                        r_fill_cnt <= r_fill_cnt - 8'd1;
                     end
                  end
                  DATA: begin
                     r_data_cnt <= r_data_cnt + 10'd1;
                     if (r_data_cnt < 10'd512)      r_tx_shift <= r_blk + r_data_cnt[7:0];
                     else if (r_data_cnt < 10'd514) r_tx_shift <= 8'h00;
                     else                           r_state    <= CMD_HUNT;
                  end
                  default: r_state <= CMD_HUNT;
               endcase
            end
         end
      end
   end

   assign sd_spi_miso_p = r_miso;
   assign card_ready_p  = r_card_ready;
   assign cmd_strobe_p  = r_cmd_strobe;
   assign last_cmd_p    = r_last_cmd;
endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for sd_spi_card_responder: a bit-banged SPI master exchanges bytes and a
// scoreboard queue holds the MISO byte expected in every byte slot.
`timescale 1ns/1ps
module tb_sd_spi_card_responder;
   localparam int NCR = 1;

   logic       clk = 1'b0, rst_n = 1'b0, sck = 1'b0, ss = 1'b1, mosi = 1'b1;
   logic       miso, ready, strobe;
   logic [5:0] last_cmd;
   int         total = 0, bad = 0, strobe_cnt = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      string       nm;
      logic [47:0] frame;
      int          n;
      logic [39:0] rsp;
      logic        rdy;
   } vec_t;
   vec_t tbl[$];

   always #2.38 clk = ~clk;

   sd_spi_card_responder #(
      .INIT_POLLS(4), .NCR_BYTES(NCR), .TOKEN_GAP(2), .CCS_BIT(1'b1)
   ) dut (
      .clk210_p      (clk),
      .reset_n_p     (rst_n),
      .sd_spi_sck_p  (sck),
      .sd_spi_ss_p   (ss),
      .sd_spi_mosi_p (mosi),
      .sd_spi_miso_p (miso),
      .card_ready_p  (ready),
      .cmd_strobe_p  (strobe),
      .last_cmd_p    (last_cmd)
   );

   always @(negedge clk) if (strobe) strobe_cnt <= strobe_cnt + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   // One SPI mode-0 byte: MISO sampled just before each rising SCK edge
   task automatic xfer_byte(input logic [7:0] mo, input string nm);
      logic [7:0] got;
      for (int b = 7; b >= 0; b--) begin
         mosi = mo[b];
         repeat (4) @(negedge clk);
         got[b] = miso;
         sck = 1'b1;
         repeat (5) @(negedge clk);
         sck = 1'b0;
         @(negedge clk);
      end
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s_sb_empty: got %02h want none", nm, got);
      end else begin
         chk(nm, {56'd0, got}, {56'd0, exp_q.pop_front()});
      end
   endtask

   task automatic ss_low();
      ss = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic ss_high();
      ss = 1'b1;
      mosi = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   function automatic vec_t mk(input string nm, input logic [47:0] fr, input int n,
                               input logic [39:0] rsp, input logic rdy);
      vec_t v;
      v.nm = nm; v.frame = fr; v.n = n; v.rsp = rsp; v.rdy = rdy;
      return v;
   endfunction

   task automatic run_cmd(input vec_t v);
      int s0;
      s0 = strobe_cnt;
      for (int i = 0; i < 6 + NCR; i++) exp_q.push_back(8'hFF);
      for (int i = 0; i < v.n; i++) exp_q.push_back(v.rsp[39-8*i -: 8]);
      exp_q.push_back(8'hFF);
      ss_low();
      for (int i = 0; i < 6; i++) xfer_byte(v.frame[47-8*i -: 8], v.nm);
      for (int i = 0; i < NCR + v.n + 1; i++) xfer_byte(8'hFF, v.nm);
      ss_high();
      chk({v.nm, "_strobe"}, 64'(strobe_cnt - s0), 64'd1);
      chk({v.nm, "_last_cmd"}, {58'd0, last_cmd}, {58'd0, v.frame[45:40]});
      chk({v.nm, "_ready"}, {63'd0, ready}, {63'd0, v.rdy});
      chk({v.nm, "_drain"}, 64'(exp_q.size()), 64'd0);
      $display("txn %-16s frame=%012h resp_bytes=%0d ready=%0b", v.nm, v.frame, v.n, ready);
   endtask

   // CMD17 read of block blk: nbytes data bytes, then either the full tail or an SS abort
   task automatic run_read(input logic [7:0] blk, input int nbytes, input logic full);
      logic [47:0] fr;
      fr = {8'h51, 24'h000000, blk, 8'h01};
      for (int i = 0; i < 6 + NCR; i++) exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFE);
      for (int i = 0; i < nbytes; i++) exp_q.push_back(8'(blk + i));
      if (full) begin
         exp_q.push_back(8'h00);
         exp_q.push_back(8'h00);
         exp_q.push_back(8'hFF);
      end
      ss_low();
      for (int i = 0; i < 6; i++) xfer_byte(fr[47-8*i -: 8], "cmd17_hdr");
      for (int i = 0; i < NCR + 4; i++) xfer_byte(8'hFF, "cmd17_hdr");
      // A frame-start pattern on MOSI during the block must not be decoded
      for (int i = 0; i < nbytes; i++) xfer_byte(full ? 8'h48 : 8'hFF, "cmd17_data");
      if (full) for (int i = 0; i < 3; i++) xfer_byte(8'hFF, "cmd17_tail");
      ss_high();
      chk("cmd17_drain", 64'(exp_q.size()), 64'd0);
      $display("txn cmd17 blk=%02h data_bytes=%0d full=%0b", blk, nbytes, full);
   endtask

   initial begin
      int s0;
      tbl.push_back(mk("cmd0",         48'h400000000095, 1, 40'h0100000000, 1'b0));
      tbl.push_back(mk("cmd0_badcrc",  48'h400000000000, 1, 40'h0900000000, 1'b0));
      tbl.push_back(mk("cmd8",         48'h48000001AA87, 5, 40'h01000001AA, 1'b0));
      tbl.push_back(mk("cmd8_badcrc",  48'h48000001AA95, 1, 40'h0900000000, 1'b0));
      tbl.push_back(mk("cmd17_idle",   48'h510000000001, 1, 40'h0500000000, 1'b0));
      tbl.push_back(mk("cmd41_noapp",  48'h690000000001, 1, 40'h0500000000, 1'b0));
      tbl.push_back(mk("cmd58_idle",   48'h7A0000000001, 5, 40'h013F800000, 1'b0));
      tbl.push_back(mk("cmd2_illegal", 48'h420000000001, 1, 40'h0500000000, 1'b0));
      for (int k = 0; k < 5; k++) begin
         tbl.push_back(mk("cmd55", 48'h770000000001, 1, 40'h0100000000, 1'b0));
         tbl.push_back(mk("acmd41", 48'h694000000001, 1,
                          (k < 4) ? 40'h0100000000 : 40'h0000000000, k == 4));
      end
      tbl.push_back(mk("cmd58_ready",  48'h7A0000000001, 5, 40'h00FF800000, 1'b1));
      tbl.push_back(mk("cmd55_ready",  48'h770000000001, 1, 40'h0000000000, 1'b1));
      tbl.push_back(mk("cmd8_after55", 48'h480000025587, 5, 40'h0000000255, 1'b1));
      tbl.push_back(mk("cmd41_rdy",    48'h690000000001, 1, 40'h0400000000, 1'b1));

      repeat (3) @(negedge clk);
      chk("rst_miso", {63'd0, miso}, 64'd1);
      chk("rst_ready", {63'd0, ready}, 64'd0);
      chk("rst_strobe", {63'd0, strobe}, 64'd0);
      chk("rst_last_cmd", {58'd0, last_cmd}, 64'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      foreach (tbl[i]) run_cmd(tbl[i]);

      // Frame cut short by SS: no strobe, and the next frame still parses
      s0 = strobe_cnt;
      repeat (3) exp_q.push_back(8'hFF);
      ss_low();
      xfer_byte(8'h40, "partial");
      xfer_byte(8'h00, "partial");
      xfer_byte(8'h00, "partial");
      ss_high();
      chk("partial_no_strobe", 64'(strobe_cnt - s0), 64'd0);
      $display("txn partial_frame bytes=3");

      run_read(8'h05, 512, 1'b1);
      run_read(8'hF0, 101, 1'b0);
      chk("abort_miso", {63'd0, miso}, 64'd1);
      chk("abort_ready", {63'd0, ready}, 64'd1);
      run_cmd(mk("cmd0_abort_bad", 48'h400000000000, 1, 40'h0800000000, 1'b1));

      // Asynchronous reset taken between clock edges
      #1 rst_n = 1'b0;
      #1;
      chk("arst_ready", {63'd0, ready}, 64'd0);
      chk("arst_last_cmd", {58'd0, last_cmd}, 64'd0);
      chk("arst_miso", {63'd0, miso}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      $display("txn async_reset");
      run_cmd(mk("post_rst_cmd17", 48'h510000000001, 1, 40'h0500000000, 1'b0));
      run_cmd(mk("post_rst_cmd55", 48'h770000000001, 1, 40'h0100000000, 1'b0));
      run_cmd(mk("post_rst_acmd41", 48'h694000000001, 1, 40'h0100000000, 1'b0));
      run_cmd(mk("post_rst_cmd58", 48'h7A0000000001, 5, 40'h013F800000, 1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
